// File: rtl/button_debouncer.sv
// Push-button debouncer: two-flop synchroniser followed by a four-state
// qualification FSM. The debounced level only flips after the synchronised
// pin has disagreed with it for STABLE_CYCLES consecutive clocks. Single-cycle
// press/release events accompany each flip.
module button_debouncer #(
  parameter int STABLE_CYCLES = 500000,
  parameter int COUNT_WIDTH   = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'b00,
    WAIT_HIGH = 2'b01,
    IDLE_HIGH = 2'b10,
    WAIT_LOW  = 2'b11
  } state_t;

  // Count value at which the next disagreeing edge completes qualification.
  localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(STABLE_CYCLES - 1);
  // With a one-cycle window the idle states flip directly, skipping WAIT_*.
  localparam bit SINGLE_CYCLE = (STABLE_CYCLES == 1);

  logic                   sync0_q;
  logic                   sync1_q;
  state_t                 state_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_inc_d;
  logic                   pressed_q;
  logic                   press_pulse_q;
  logic                   release_pulse_q;

  // Two-flop synchroniser; raw_in is asynchronous to clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
    end else begin
      sync0_q <= raw_in;
      sync1_q <= sync0_q;
    end
  end

  // Incremented stability count; only used in WAIT_* below LAST_COUNT, so it never wraps.
  always_comb begin
    count_inc_d = count_q + COUNT_WIDTH'(1);
  end

  // Qualification FSM with registered level and one-shot event outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE_LOW;
      count_q         <= '0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
    end else begin
      // Pulses live for one cycle only; a flip below re-asserts the relevant one.
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      case (state_q)
        IDLE_LOW: begin
          if (sync1_q) begin
            if (SINGLE_CYCLE) begin
              state_q       <= IDLE_HIGH;
              count_q       <= '0;
              pressed_q     <= 1'b1;
              press_pulse_q <= 1'b1;
            end else begin
              state_q <= WAIT_HIGH;
              count_q <= COUNT_WIDTH'(1);
            end
          end else begin
            count_q <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!sync1_q) begin
            // Glitch shorter than the window: drop it silently.
            state_q <= IDLE_LOW;
            count_q <= '0;
          end else if (count_q == LAST_COUNT) begin
            state_q       <= IDLE_HIGH;
            count_q       <= '0;
            pressed_q     <= 1'b1;
            press_pulse_q <= 1'b1;
          end else begin
            count_q <= count_inc_d;
          end
        end
        IDLE_HIGH: begin
          if (!sync1_q) begin
            if (SINGLE_CYCLE) begin
              state_q         <= IDLE_LOW;
              count_q         <= '0;
              pressed_q       <= 1'b0;
              release_pulse_q <= 1'b1;
            end else begin
              state_q <= WAIT_LOW;
              count_q <= COUNT_WIDTH'(1);
            end
          end else begin
            count_q <= '0;
          end
        end
        WAIT_LOW: begin
          if (sync1_q) begin
            state_q <= IDLE_HIGH;
            count_q <= '0;
          end else if (count_q == LAST_COUNT) begin
            state_q         <= IDLE_LOW;
            count_q         <= '0;
            pressed_q       <= 1'b0;
            release_pulse_q <= 1'b1;
          end else begin
            count_q <= count_inc_d;
          end
        end
        default: begin
          // Unreachable encodings recover to the reset condition.
          state_q   <= IDLE_LOW;
          count_q   <= '0;
          pressed_q <= 1'b0;
        end
      endcase
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer. Two instances share the clock:
// dut_a uses a 4-cycle window, dut_b a 1-cycle window. Stimulus processes
// push the hand-computed {pressed, press_pulse, release_pulse} expected after
// each clock edge; per-DUT monitors pop and compare on the falling edge.
module tb_button_debouncer;

  logic clk;
  logic rst_a, raw_a, pressed_a, press_a, release_a;
  logic rst_b, raw_b, pressed_b, press_b, release_b;

  int checks;
  int errors;

  logic [2:0] q_a[$];
  logic [2:0] q_b[$];

  button_debouncer #(.STABLE_CYCLES(4), .COUNT_WIDTH(20)) dut_a (
    .clk          (clk),
    .reset        (rst_a),
    .raw_in       (raw_a),
    .pressed      (pressed_a),
    .press_pulse  (press_a),
    .release_pulse(release_a)
  );

  button_debouncer #(.STABLE_CYCLES(1), .COUNT_WIDTH(20)) dut_b (
    .clk          (clk),
    .reset        (rst_b),
    .raw_in       (raw_b),
    .pressed      (pressed_b),
    .press_pulse  (press_b),
    .release_pulse(release_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge for dut_a: record what must be visible after it, then set the pin for the next edge.
  task automatic step_a(input logic raw_next, input logic [2:0] exp);
    @(posedge clk);
    #1;
    q_a.push_back(exp);
    raw_a = raw_next;
  endtask

  task automatic step_b(input logic raw_next, input logic [2:0] exp);
    @(posedge clk);
    #1;
    q_b.push_back(exp);
    raw_b = raw_next;
  endtask

  // Monitor for dut_a.
  always @(negedge clk) begin
    if (q_a.size() > 0) begin
      logic [2:0] exp;
      logic [2:0] act;
      exp = q_a.pop_front();
      act = {pressed_a, press_a, release_a};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL dut_a outputs t=%0t actual=%b required=%b", $time, act, exp);
      end else begin
        $display("dut_a t=%0t raw=%b pressed/press/release=%b", $time, raw_a, act);
      end
    end
  end

  // Monitor for dut_b.
  always @(negedge clk) begin
    if (q_b.size() > 0) begin
      logic [2:0] exp;
      logic [2:0] act;
      exp = q_b.pop_front();
      act = {pressed_b, press_b, release_b};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL dut_b outputs t=%0t actual=%b required=%b", $time, act, exp);
      end else begin
        $display("dut_b t=%0t raw=%b pressed/press/release=%b", $time, raw_b, act);
      end
    end
  end

  // Stimulus for the 4-cycle instance.
  task automatic run_a();
    logic [7:0] bounce;
    rst_a = 1'b1;
    raw_a = 1'b0;
    for (int i = 0; i < 3; i++) step_a(1'b0, 3'b000);
    rst_a = 1'b0;
    // Idle low after reset.
    for (int i = 0; i < 20; i++) step_a(1'b0, 3'b000);
    // Bounce: 1 x3, 0, 1 x3, then 0 -- never four agreeing edges.
    bounce = 8'b01110111;
    for (int i = 0; i < 8; i++) step_a(bounce[i], 3'b000);
    for (int i = 0; i < 10; i++) step_a(1'b0, 3'b000);
    // Press: raw high before edge 0, level flips at edge 5.
    step_a(1'b1, 3'b000);
    for (int e = 0; e <= 12; e++)
      step_a(1'b1, (e < 5) ? 3'b000 : (e == 5) ? 3'b110 : 3'b100);
    // Release: raw low before edge 0, level drops at edge 5.
    step_a(1'b0, 3'b100);
    for (int e = 0; e <= 12; e++)
      step_a(1'b0, (e < 5) ? 3'b100 : (e == 5) ? 3'b001 : 3'b000);
    // Press again so the reset phase starts from pressed = 1.
    step_a(1'b1, 3'b000);
    for (int e = 0; e <= 12; e++)
      step_a(1'b1, (e < 5) ? 3'b000 : (e == 5) ? 3'b110 : 3'b100);
    // Reset between edges 3 and 4 with raw held high; released before edge 6.
    for (int e = 0; e <= 2; e++) step_a(1'b1, 3'b100);
    @(posedge clk);
    #3;
    rst_a = 1'b1;
    q_a.push_back(3'b000);
    step_a(1'b1, 3'b000);
    step_a(1'b1, 3'b000);
    #6;
    rst_a = 1'b0;
    for (int e = 6; e <= 14; e++)
      step_a(1'b1, (e < 11) ? 3'b000 : (e == 11) ? 3'b110 : 3'b100);
  endtask

  // Stimulus for the 1-cycle instance: pin toggles every 4 edges, level follows 2 edges later.
  task automatic run_b();
    logic       lvl;
    logic [2:0] exp;
    int         ph;
    rst_b = 1'b1;
    raw_b = 1'b0;
    for (int i = 0; i < 3; i++) step_b(1'b0, 3'b000);
    rst_b = 1'b0;
    for (int i = 0; i < 5; i++) step_b(1'b0, 3'b000);
    step_b(1'b1, 3'b000);
    for (int e = 0; e < 32; e++) begin
      if (e < 2) begin
        exp = 3'b000;
      end else begin
        ph  = e - 2;
        lvl = (((ph >> 2) & 1) == 0);
        exp = {lvl, lvl && (ph % 4 == 0), !lvl && (ph % 4 == 0)};
      end
      step_b((((e + 1) >> 2) & 1) == 0, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_a  = 1'b1;
    rst_b  = 1'b1;
    raw_a  = 1'b0;
    raw_b  = 1'b0;
    fork
      run_a();
      run_b();
    join
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (q_a.size() != 0) begin
      errors++;
      $display("FAIL drain_a pending=%0d required=0", q_a.size());
    end
    checks++;
    if (q_b.size() != 0) begin
      errors++;
      $display("FAIL drain_b pending=%0d required=0", q_b.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #200000;
    $display("FAIL watchdog elapsed=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
